// File: rtl/life_row_engine.sv
// Four-row Game-of-Life row engine: loads rows into a shadow array, computes the next generation from the current array, and writes it back.
// Optional build macro POPULATION_EN adds a registered live-cell count of the current array.
module life_row_engine #(
  parameter int WIDTH     = 8,
  parameter int GEN_W     = 16,
  parameter int WRAP_COLS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write_array,
  input  logic             run,
  input  logic [1:0]       pos,
  input  logic             write_mem,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [1:0]       mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  output logic             frame_valid,
  output logic [GEN_W-1:0] gen_count,
  output logic             seq_err
`ifdef POPULATION_EN
  ,
  output logic [$clog2(4*WIDTH+1)-1:0] population
`endif
);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_RUN   = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  logic [WIDTH-1:0] r_shadow [4];
  logic [WIDTH-1:0] r_cur    [4];
  logic [WIDTH-1:0] r_next   [4];
  logic             r_frameValid;
  logic [GEN_W-1:0] r_genCount;
  logic             r_seqErr;

  state_t           r_state;
  state_t           w_nextState;
  logic [1:0]       r_expPos;
  logic [1:0]       w_nextExpPos;
  logic             w_expStrobe;
  logic             w_anyStrobe;
  logic             w_multiStrobe;
  logic             w_violation;
  logic             w_advance;

  logic [1:0]       w_posUp;
  logic [1:0]       w_posDn;
  logic [WIDTH-1:0] w_rowUp;
  logic [WIDTH-1:0] w_rowMid;
  logic [WIDTH-1:0] w_rowDn;
  logic [WIDTH-1:0] w_nextRow;
  logic             w_frameEnd;

  // Rows are always toroidal, so the 2-bit row index simply wraps.
  assign w_posUp  = pos - 2'd1;
  assign w_posDn  = pos + 2'd1;
  assign w_rowUp  = r_cur[w_posUp];
  assign w_rowMid = r_cur[pos];
  assign w_rowDn  = r_cur[w_posDn];

  for (genvar c = 0; c < WIDTH; c++) begin : g_col
    localparam int L     = (c == 0) ? WIDTH - 1 : c - 1;
    localparam int R     = (c == WIDTH - 1) ? 0 : c + 1;
    localparam bit HAS_L = (c != 0) || (WRAP_COLS != 0);
    localparam bit HAS_R = (c != WIDTH - 1) || (WRAP_COLS != 0);

    logic [7:0] w_nb;
    logic [3:0] w_sum;

    // Edge columns either borrow from the opposite edge or see dead cells.
    assign w_nb = {w_rowUp[L] & HAS_L, w_rowUp[c], w_rowUp[R] & HAS_R,
                   w_rowMid[L] & HAS_L,            w_rowMid[R] & HAS_R,
                   w_rowDn[L] & HAS_L, w_rowDn[c], w_rowDn[R] & HAS_R};

    always_comb begin
      w_sum = 4'd0;
      for (int k = 0; k < 8; k++) begin
        w_sum = w_sum + {3'b000, w_nb[k]};
      end
    end

    assign w_nextRow[c] = (w_sum == 4'd3) | (w_rowMid[c] & (w_sum == 4'd2));
  end

  assign w_frameEnd = write_mem & (pos == 2'd3);

  // Array updates follow the raw strobes even after a protocol violation.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < 4; r++) begin
        r_shadow[r] <= '0;
        r_cur[r]    <= '0;
        r_next[r]   <= '0;
      end
      r_frameValid <= 1'b0;
      r_genCount   <= '0;
    end else begin
      if (write_array) begin
        r_shadow[pos] <= mem_rdata;
      end
      if (run) begin
        r_next[pos] <= w_nextRow;
      end
      if (w_frameEnd) begin
        r_cur        <= r_shadow;
        r_frameValid <= 1'b1;
        if (r_frameValid) begin
          r_genCount <= r_genCount + GEN_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_LOAD;
      r_expPos <= 2'd0;
      r_seqErr <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_expPos <= w_nextExpPos;
      r_seqErr <= r_seqErr | w_violation;
    end
  end

  always_comb begin
    w_nextState  = r_state;
    w_nextExpPos = r_expPos;
    if (w_advance) begin
      case (r_state)
        S_LOAD:  w_nextState = S_RUN;
        S_RUN:   w_nextState = S_WRITE;
        S_WRITE: begin
          w_nextState  = S_LOAD;
          w_nextExpPos = r_expPos + 2'd1;
        end
        default: w_nextState = S_LOAD;
      endcase
    end
  end

  // Idle cycles are legal; any single strobe must match both state and row.
  always_comb begin
    w_expStrobe = 1'b0;
    case (r_state)
      S_LOAD:  w_expStrobe = write_array;
      S_RUN:   w_expStrobe = run;
      S_WRITE: w_expStrobe = write_mem;
      default: w_expStrobe = 1'b0;
    endcase
    w_anyStrobe   = write_array | run | write_mem;
    w_multiStrobe = (write_array & run) | (write_array & write_mem) | (run & write_mem);
    w_violation   = w_anyStrobe & (w_multiStrobe | ~w_expStrobe | (pos != r_expPos));
    w_advance     = w_anyStrobe & ~w_violation;
  end

  assign mem_addr    = pos;
  assign mem_wdata   = r_next[pos];
  assign mem_we      = write_mem & r_frameValid & ~r_seqErr;
  assign frame_valid = r_frameValid;
  assign gen_count   = r_genCount;
  assign seq_err     = r_seqErr;

`ifdef POPULATION_EN
  localparam int POP_W = $clog2(4*WIDTH+1);

  logic [POP_W-1:0] w_popSum;
  logic [POP_W-1:0] r_population;

  always_comb begin
    w_popSum = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < WIDTH; c++) begin
        w_popSum = w_popSum + POP_W'(r_cur[r][c]);
      end
    end
  end

  // Counted from the registered array, so it trails each load by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_population <= '0;
    end else begin
      r_population <= w_popSum;
    end
  end

  assign population = r_population;
`endif

endmodule

// File: tb/tb_life_row_engine.sv
// Directed bench for life_row_engine: three instances (default, non-wrapping columns, 2-bit generation counter) share one strobe stream.
// Population checks are compiled in only when POPULATION_EN is defined.
module tb_life_row_engine;

  logic       clk;
  logic       reset;
  logic       writeArray;
  logic       run;
  logic [1:0] pos;
  logic       writeMem;
  logic [7:0] memRdata;

  logic [1:0]  mainAddr,  nwAddr,  smAddr;
  logic [7:0]  mainWdata, nwWdata, smWdata;
  logic        mainWe,    nwWe,    smWe;
  logic        mainFv,    nwFv,    smFv;
  logic [15:0] mainGen,   nwGen;
  logic [1:0]  smGen;
  logic        mainErr,   nwErr,   smErr;
`ifdef POPULATION_EN
  logic [5:0]  mainPop,   nwPop,   smPop;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] capData [4];
  logic [1:0] capAddr [4];
  logic       capWe   [4];
  logic [7:0] capNwData [4];
  logic       capNwWe   [4];

  life_row_engine #(.WIDTH(8), .GEN_W(16), .WRAP_COLS(1)) dutMain (
    .clk(clk), .reset(reset), .write_array(writeArray), .run(run), .pos(pos),
    .write_mem(writeMem), .mem_rdata(memRdata), .mem_addr(mainAddr),
    .mem_wdata(mainWdata), .mem_we(mainWe), .frame_valid(mainFv),
    .gen_count(mainGen), .seq_err(mainErr)
`ifdef POPULATION_EN
    , .population(mainPop)
`endif
  );

  life_row_engine #(.WIDTH(8), .GEN_W(16), .WRAP_COLS(0)) dutNoWrap (
    .clk(clk), .reset(reset), .write_array(writeArray), .run(run), .pos(pos),
    .write_mem(writeMem), .mem_rdata(memRdata), .mem_addr(nwAddr),
    .mem_wdata(nwWdata), .mem_we(nwWe), .frame_valid(nwFv),
    .gen_count(nwGen), .seq_err(nwErr)
`ifdef POPULATION_EN
    , .population(nwPop)
`endif
  );

  life_row_engine #(.WIDTH(8), .GEN_W(2), .WRAP_COLS(1)) dutSmall (
    .clk(clk), .reset(reset), .write_array(writeArray), .run(run), .pos(pos),
    .write_mem(writeMem), .mem_rdata(memRdata), .mem_addr(smAddr),
    .mem_wdata(smWdata), .mem_we(smWe), .frame_valid(smFv),
    .gen_count(smGen), .seq_err(smErr)
`ifdef POPULATION_EN
    , .population(smPop)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge so every rising edge sees stable strobes.
  task automatic drive(input logic wa, input logic rn, input logic wm,
                       input logic [1:0] p, input logic [7:0] d);
    @(negedge clk);
    writeArray = wa;
    run        = rn;
    writeMem   = wm;
    pos        = p;
    memRdata   = d;
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1;
    writeArray = 1'b0; run = 1'b0; writeMem = 1'b0; pos = 2'd0; memRdata = 8'h00;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One full frame in checker order; write-back cycles are captured mid-cycle.
  task automatic runFrame(input logic [7:0] r0, input logic [7:0] r1,
                          input logic [7:0] r2, input logic [7:0] r3, input bit idle);
    logic [7:0] rows [4];
    rows[0] = r0; rows[1] = r1; rows[2] = r2; rows[3] = r3;
    for (int p = 0; p < 4; p++) begin
      drive(1'b1, 1'b0, 1'b0, 2'(p), rows[p]);
      if (idle) drive(1'b0, 1'b0, 1'b0, 2'(p), 8'h00);
      drive(1'b0, 1'b1, 1'b0, 2'(p), 8'h00);
      if (idle) drive(1'b0, 1'b0, 1'b0, 2'(p), 8'h00);
      drive(1'b0, 1'b0, 1'b1, 2'(p), 8'h00);
      #1;
      capData[p]   = mainWdata;
      capAddr[p]   = mainAddr;
      capWe[p]     = mainWe;
      capNwData[p] = nwWdata;
      capNwWe[p]   = nwWe;
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic test_reset();
    applyReset();
    #1;
    checks++; if (mainFv !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_valid got %b want 0", mainFv); end
    checks++; if (mainGen !== 16'd0) begin errors++; $display("[TB] FAIL reset_gen_count got %0d want 0", mainGen); end
    checks++; if (mainErr !== 1'b0) begin errors++; $display("[TB] FAIL reset_seq_err got %b want 0", mainErr); end
    checks++; if (mainWdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_wdata got %h want 00", mainWdata); end
`ifdef POPULATION_EN
    checks++; if (mainPop !== 6'd0) begin errors++; $display("[TB] FAIL reset_population got %0d want 0", mainPop); end
`endif
  endtask

  task automatic test_blinker();
    logic [7:0] expW [4];
    expW = '{8'h08, 8'h08, 8'h08, 8'h00};
    applyReset();
    runFrame(8'h00, 8'h1C, 8'h00, 8'h00, 1'b0);
    for (int p = 0; p < 4; p++) begin
      checks++; if (capWe[p] !== 1'b0) begin errors++; $display("[TB] FAIL blinker_first_frame_we row%0d got %b want 0", p, capWe[p]); end
    end
    checks++; if (mainFv !== 1'b1) begin errors++; $display("[TB] FAIL blinker_frame_valid got %b want 1", mainFv); end
    checks++; if (mainGen !== 16'd0) begin errors++; $display("[TB] FAIL blinker_gen_frame1 got %0d want 0", mainGen); end
    runFrame(8'h00, 8'h1C, 8'h00, 8'h00, 1'b0);
    for (int p = 0; p < 4; p++) begin
      checks++; if (capWe[p] !== 1'b1) begin errors++; $display("[TB] FAIL blinker_we row%0d got %b want 1", p, capWe[p]); end
      checks++; if (capAddr[p] !== 2'(p)) begin errors++; $display("[TB] FAIL blinker_addr row%0d got %0d want %0d", p, capAddr[p], p); end
      checks++; if (capData[p] !== expW[p]) begin errors++; $display("[TB] FAIL blinker_wdata row%0d got %h want %h", p, capData[p], expW[p]); end
    end
    checks++; if (mainGen !== 16'd1) begin errors++; $display("[TB] FAIL blinker_gen_frame2 got %0d want 1", mainGen); end
  endtask

  task automatic test_still_block();
    logic [7:0] expW [4];
    expW = '{8'h00, 8'h18, 8'h18, 8'h00};
    applyReset();
    runFrame(8'h00, 8'h18, 8'h18, 8'h00, 1'b1);
    for (int f = 1; f <= 3; f++) begin
      runFrame(8'h00, 8'h18, 8'h18, 8'h00, 1'b1);
      for (int p = 0; p < 4; p++) begin
        checks++; if (capWe[p] !== 1'b1 || capData[p] !== expW[p]) begin
          errors++; $display("[TB] FAIL still_write frame%0d row%0d got we=%b %h want we=1 %h", f, p, capWe[p], capData[p], expW[p]);
        end
      end
      checks++; if (mainGen !== 16'(f)) begin errors++; $display("[TB] FAIL still_gen frame%0d got %0d want %0d", f, mainGen, f); end
    end
    checks++; if (mainErr !== 1'b0) begin errors++; $display("[TB] FAIL still_idle_seq_err got %b want 0", mainErr); end
  endtask

  task automatic test_wrap_cols();
    logic [7:0] expW [4];
    expW = '{8'h01, 8'h01, 8'h01, 8'h00};
    applyReset();
    runFrame(8'h00, 8'h83, 8'h00, 8'h00, 1'b0);
    runFrame(8'h00, 8'h83, 8'h00, 8'h00, 1'b0);
    for (int p = 0; p < 4; p++) begin
      checks++; if (capWe[p] !== 1'b1 || capData[p] !== expW[p]) begin
        errors++; $display("[TB] FAIL wrap_on row%0d got we=%b %h want we=1 %h", p, capWe[p], capData[p], expW[p]);
      end
      checks++; if (capNwWe[p] !== 1'b1 || capNwData[p] !== 8'h00) begin
        errors++; $display("[TB] FAIL wrap_off row%0d got we=%b %h want we=1 00", p, capNwWe[p], capNwData[p]);
      end
    end
  endtask

  task automatic test_seq_err();
    applyReset();
    drive(1'b0, 1'b1, 1'b0, 2'd2, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    #1;
    checks++; if (mainErr !== 1'b1) begin errors++; $display("[TB] FAIL seq_err_wrong_strobe got %b want 1", mainErr); end
    runFrame(8'h00, 8'h1C, 8'h00, 8'h00, 1'b0);
    runFrame(8'h00, 8'h1C, 8'h00, 8'h00, 1'b0);
    for (int p = 0; p < 4; p++) begin
      checks++; if (capWe[p] !== 1'b0) begin errors++; $display("[TB] FAIL seq_err_blocks_we row%0d got %b want 0", p, capWe[p]); end
    end
    checks++; if (mainFv !== 1'b1 || mainGen !== 16'd1) begin
      errors++; $display("[TB] FAIL seq_err_raw_updates got fv=%b gen=%0d want fv=1 gen=1", mainFv, mainGen);
    end
    checks++; if (capData[0] !== 8'h08) begin errors++; $display("[TB] FAIL seq_err_raw_compute got %h want 08", capData[0]); end
    checks++; if (mainErr !== 1'b1) begin errors++; $display("[TB] FAIL seq_err_sticky got %b want 1", mainErr); end
    applyReset();
    #1;
    checks++; if (mainErr !== 1'b0) begin errors++; $display("[TB] FAIL seq_err_cleared got %b want 0", mainErr); end
    drive(1'b1, 1'b0, 1'b0, 2'd1, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    #1;
    checks++; if (mainErr !== 1'b1) begin errors++; $display("[TB] FAIL seq_err_pos_mismatch got %b want 1", mainErr); end
    applyReset();
    drive(1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    #1;
    checks++; if (mainErr !== 1'b1) begin errors++; $display("[TB] FAIL seq_err_multi_strobe got %b want 1", mainErr); end
    applyReset();
    drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 2'd0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    #1;
    checks++; if (mainErr !== 1'b0) begin errors++; $display("[TB] FAIL seq_err_legal_start got %b want 0", mainErr); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] expW [4];
    expW = '{8'h08, 8'h08, 8'h08, 8'h00};
    applyReset();
    runFrame(8'h00, 8'h1C, 8'h00, 8'h00, 1'b0);
    runFrame(8'h00, 8'h1C, 8'h00, 8'h00, 1'b0);
    for (int p = 0; p < 2; p++) begin
      drive(1'b1, 1'b0, 1'b0, 2'(p), (p == 1) ? 8'h1C : 8'h00);
      drive(1'b0, 1'b1, 1'b0, 2'(p), 8'h00);
      drive(1'b0, 1'b0, 1'b1, 2'(p), 8'h00);
    end
    drive(1'b1, 1'b0, 1'b0, 2'd2, 8'h00);
    @(negedge clk);
    reset = 1'b1; writeArray = 1'b0; run = 1'b1; writeMem = 1'b0; pos = 2'd2;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    reset = 1'b0;
    #1;
    checks++; if (mainGen !== 16'd0) begin errors++; $display("[TB] FAIL midreset_gen got %0d want 0", mainGen); end
    checks++; if (mainFv !== 1'b0) begin errors++; $display("[TB] FAIL midreset_frame_valid got %b want 0", mainFv); end
    checks++; if (mainWdata !== 8'h00) begin errors++; $display("[TB] FAIL midreset_next_cleared got %h want 00", mainWdata); end
    runFrame(8'h00, 8'h1C, 8'h00, 8'h00, 1'b0);
    for (int p = 0; p < 4; p++) begin
      checks++; if (capWe[p] !== 1'b0) begin errors++; $display("[TB] FAIL midreset_no_we row%0d got %b want 0", p, capWe[p]); end
    end
    runFrame(8'h00, 8'h1C, 8'h00, 8'h00, 1'b0);
    for (int p = 0; p < 4; p++) begin
      checks++; if (capWe[p] !== 1'b1 || capData[p] !== expW[p]) begin
        errors++; $display("[TB] FAIL midreset_recover row%0d got we=%b %h want we=1 %h", p, capWe[p], capData[p], expW[p]);
      end
    end
  endtask

  task automatic test_gen_wrap();
    logic [1:0] expGen [5];
    expGen = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    applyReset();
    runFrame(8'h00, 8'h1C, 8'h00, 8'h00, 1'b0);
    for (int k = 0; k < 5; k++) begin
      runFrame(8'h00, 8'h1C, 8'h00, 8'h00, 1'b0);
      checks++; if (smGen !== expGen[k]) begin errors++; $display("[TB] FAIL gen_wrap_small frame%0d got %0d want %0d", k + 1, smGen, expGen[k]); end
      checks++; if (mainGen !== 16'(k + 1)) begin errors++; $display("[TB] FAIL gen_wide frame%0d got %0d want %0d", k + 1, mainGen, k + 1); end
`ifdef POPULATION_EN
      checks++; if (smPop !== 6'd3) begin errors++; $display("[TB] FAIL population frame%0d got %0d want 3", k + 1, smPop); end
`endif
    end
  endtask

  initial begin
    reset = 1'b1;
    writeArray = 1'b0; run = 1'b0; writeMem = 1'b0; pos = 2'd0; memRdata = 8'h00;
    test_reset();
    test_blinker();
    test_still_block();
    test_wrap_cols();
    test_seq_err();
    test_reset_midframe();
    test_gen_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
